// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD host command-line transmitter.
// Holds the serializer state type, frame-length constants and the CRC7
// polynomial with a one-bit CRC update helper.
package sd_cmd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // x^7 + x^3 + 1 with the implicit x^7 term dropped
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int SD_CMD_FRAME_W = 48;
    localparam int SD_CMD_LONG_W  = 136;

    // Advance a CRC7 register by one message bit (MSB-first, no reflection)
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator for SD command frames.
// Clear has priority over the bit enable; the result is the registered
// remainder after every enabled bit seen since the last clear.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    // Restart from zero on clear, otherwise fold in one bit per enabled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= 7'h00;
        end else if (i_clear) begin
            r_crc <= 7'h00;
        end else if (i_en) begin
            r_crc <= crc7_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line serializer: takes a parallel frame on a valid/ready handshake
// and shifts it out one bit per clock with a pad output-enable.
// Optional feature macro SD_CMD_TX_CRC7_EN: the seven bits before the last
// are replaced by CRC7 over the preceding bits and the last bit is forced
// to 1, so the caller's low byte is ignored (MSB-first only).
module sd_cmd_tx
    import sd_cmd_pkg::*;
#(
    parameter int WIDTH      = SD_CMD_FRAME_W,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_en,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shiftReg;
    logic [CW-1:0]    r_bitCnt;
    logic             r_out;
    logic             r_outEn;
    logic             r_done;

    logic [WIDTH-1:0] w_loadFrame;
    logic [WIDTH-1:0] w_loadShift;
    logic             w_firstBit;
    logic [WIDTH-1:0] w_nextShift;
    logic             w_nextOut;

`ifdef SD_CMD_TX_CRC7_EN
    logic [6:0] w_crc;
    logic [6:0] w_crcFinal;
    logic       w_crcClear;
    logic       w_crcEn;

    if (!MSB_FIRST) begin : g_badCfg
        $error("sd_cmd_tx: CRC7 insertion requires MSB_FIRST=1");
    end

    assign w_crcClear  = (r_state == IDLE) && in_valid;
    assign w_crcEn     = (r_state == SHIFT) && (r_bitCnt < CW'(WIDTH - 8));
    assign w_crcFinal  = crc7_step(w_crc, r_out);
    assign w_loadFrame = (in & ~WIDTH'(8'hFF)) | WIDTH'(1);

    sd_crc7 u_crc7 (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_crcClear),
        .i_en    (w_crcEn),
        .i_bit   (r_out),
        .o_crc   (w_crc)
    );
`else
    assign w_loadFrame = in;
`endif

    assign w_firstBit  = MSB_FIRST ? w_loadFrame[WIDTH-1] : w_loadFrame[0];
    assign w_loadShift = MSB_FIRST ? (w_loadFrame << 1) : (w_loadFrame >> 1);

    // Pick the next bit to present and the shifted register; with CRC enabled
    // the CRC bits and end bit are spliced in just before the CRC field starts
    always_comb begin
        w_nextOut   = MSB_FIRST ? r_shiftReg[WIDTH-1] : r_shiftReg[0];
        w_nextShift = MSB_FIRST ? (r_shiftReg << 1) : (r_shiftReg >> 1);
`ifdef SD_CMD_TX_CRC7_EN
        if ((WIDTH > 8) && (r_bitCnt == CW'(WIDTH - 9))) begin
            w_nextOut   = w_crcFinal[6];
            w_nextShift = {w_crcFinal[5:0], 1'b1, {(WIDTH-7){1'b0}}};
        end
`endif
    end

    // Frame sequencer: load on handshake, emit one bit per cycle, pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_out      <= IDLE_LEVEL;
            r_outEn    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= SHIFT;
                        r_shiftReg <= w_loadShift;
                        r_bitCnt   <= '0;
                        r_out      <= w_firstBit;
                        r_outEn    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_bitCnt == LAST) begin
                        r_state    <= IDLE;
                        r_shiftReg <= '0;
                        r_out      <= IDLE_LEVEL;
                        r_outEn    <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_bitCnt   <= r_bitCnt + CW'(1);
                        r_shiftReg <= w_nextShift;
                        r_out      <= w_nextOut;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state == SHIFT);
    assign out      = r_out;
    assign out_en   = r_outEn;
    assign done     = r_done;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx (48-bit MSB-first instance, plus an
// 8-bit LSB-first instance when SD_CMD_TX_CRC7_EN is not defined).
module tb_sd_cmd_tx;

    localparam int   W    = 48;
    localparam logic IDLE = 1'b1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         dinValid = 1'b0;
    logic         inReady;
    logic         dout;
    logic         outEn;
    logic         busy;
    logic         done;

    int testsRun  = 0;
    int failCount = 0;

    // Free-running 100 MHz style clock
    always #5 clk = ~clk;

    sd_cmd_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .in_valid (dinValid),
        .in_ready (inReady),
        .out      (dout),
        .out_en   (outEn),
        .busy     (busy),
        .done     (done)
    );

`ifndef SD_CMD_TX_CRC7_EN
    logic [7:0] lsbIn = '0;
    logic       lsbValid = 1'b0;
    logic       lsbReady;
    logic       lsbOut;
    logic       lsbOutEn;
    logic       lsbBusy;
    logic       lsbDone;

    sd_cmd_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) u_lsb (
        .clk      (clk),
        .reset    (reset),
        .in       (lsbIn),
        .in_valid (lsbValid),
        .in_ready (lsbReady),
        .out      (lsbOut),
        .out_en   (lsbOutEn),
        .busy     (lsbBusy),
        .done     (lsbDone)
    );
`endif

    // Reference: the frame as it should appear on the wire, first bit at MSB
    function automatic logic [W-1:0] expectedTx(input logic [W-1:0] frame);
`ifdef SD_CMD_TX_CRC7_EN
        logic [W-2:0] work;
        work = {frame[W-1:8], 7'b0};
        for (int i = W - 2; i >= 7; i--) begin
            if (work[i]) work[i -: 8] = work[i -: 8] ^ 8'h89;
        end
        return {frame[W-1:8], work[6:0], 1'b1};
`else
        return frame;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [135:0] observed,
                               input logic [135:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a frame and wait (bounded) for the handshake edge
    task automatic applyStimulus(input logic [W-1:0] frame, input bit keepValid);
        @(negedge clk);
        din      = frame;
        dinValid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (inReady) break;
            @(negedge clk);
        end
        if (!inReady) checkOutput("handshakeTimeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keepValid) dinValid = 1'b0;
    endtask

    // Capture W bits starting the cycle after the handshake
    task automatic collectFrame(input int validOnAt, input int validOffAt,
                                output logic [W-1:0] got, output int enCnt,
                                output int doneCnt, output int readyCnt,
                                output int busyCnt);
        logic [W-1:0] saved;
        saved    = din;
        got      = '0;
        enCnt    = 0;
        doneCnt  = 0;
        readyCnt = 0;
        busyCnt  = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            got[W-1-i] = dout;
            enCnt    += int'(outEn);
            doneCnt  += int'(done);
            readyCnt += int'(inReady);
            busyCnt  += int'(busy);
            if (i == validOnAt) begin
                din      = ~saved;
                dinValid = 1'b1;
            end
            if (i == validOffAt) begin
                dinValid = 1'b0;
                din      = saved;
            end
        end
    endtask

    task automatic finishFrame(input string tag);
        @(negedge clk);
        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".readyAfter"}, inReady, 1);
        checkOutput({tag, ".idleOut"}, {outEn, dout}, {1'b0, IDLE});
    endtask

    task automatic sendAndCheck(input string tag, input logic [W-1:0] frame,
                                input int pulseAt);
        logic [W-1:0] got;
        int enCnt, doneCnt, readyCnt, busyCnt;
        applyStimulus(frame, 1'b0);
        collectFrame(pulseAt, (pulseAt < 0) ? -1 : pulseAt + 3,
                     got, enCnt, doneCnt, readyCnt, busyCnt);
        checkOutput({tag, ".frame"}, got, expectedTx(frame));
        checkOutput({tag, ".outEnCycles"}, enCnt, W);
        checkOutput({tag, ".busyCycles"}, busyCnt, W);
        checkOutput({tag, ".earlyDoneOrReady"}, doneCnt + readyCnt, 0);
        finishFrame(tag);
    endtask

    initial begin
        logic [W-1:0] fa, fb, got;
        int enCnt, doneCnt, readyCnt, busyCnt;

        // Reset state
        #12;
        checkOutput("reset.outputs", {dout, outEn, busy, done}, {IDLE, 3'b000});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.inReady", inReady, 1);
        checkOutput("idle.outputs", {dout, outEn, busy, done}, {IDLE, 3'b000});

        // Directed reference vectors
`ifdef SD_CMD_TX_CRC7_EN
        checkOutput("model.cmd0", expectedTx(48'h40_0000_0000_00), 48'h40_0000_0000_95);
        checkOutput("model.cmd8", expectedTx(48'h48_0000_01AA_00), 48'h48_0000_01AA_87);
        sendAndCheck("cmd0", 48'h40_0000_0000_00, -1);
        sendAndCheck("cmd8", 48'h48_0000_01AA_00, -1);
`else
        sendAndCheck("fixed", 48'hADEB_AEBA_AA75, -1);
`endif

        // Randomized frames, some with a stray in_valid pulse mid-frame
        for (int k = 0; k < 6; k++) begin
            fa = {$urandom(), $urandom()};
            sendAndCheck($sformatf("rand%0d", k), fa,
                         (k % 2 == 1) ? int'($urandom_range(1, W - 6)) : -1);
        end

        // Back-to-back frames with in_valid held high throughout
        fa = {$urandom(), $urandom()};
        fb = {$urandom(), $urandom()};
        applyStimulus(fa, 1'b1);
        din = fb;
        collectFrame(-1, -1, got, enCnt, doneCnt, readyCnt, busyCnt);
        checkOutput("b2b.first", got, expectedTx(fa));
        finishFrame("b2b.gap");
        collectFrame(-1, 0, got, enCnt, doneCnt, readyCnt, busyCnt);
        checkOutput("b2b.second", got, expectedTx(fb));
        checkOutput("b2b.secondEn", enCnt, W);
        finishFrame("b2b.end");

        // Asynchronous reset during bit 20, then a clean frame
        fa = {$urandom(), $urandom()};
        applyStimulus(fa, 1'b0);
        for (int i = 0; i <= 20; i++) @(negedge clk);
        fb = expectedTx(fa);
        checkOutput("abort.bit20", dout, fb[W-21]);
        reset = 1'b1;
        #1;
        checkOutput("abort.async", {dout, outEn, busy, done}, {IDLE, 3'b000});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort.readyAfter", inReady, 1);
        checkOutput("abort.stillIdle", {dout, outEn, busy}, {IDLE, 2'b00});
        sendAndCheck("postAbort", {$urandom(), $urandom()}, -1);

`ifndef SD_CMD_TX_CRC7_EN
        // LSB-first 8-bit instance: bit 0 leaves first
        for (int k = 0; k < 2; k++) begin
            logic [7:0] lf, lg;
            int lEn, lBusy;
            lf = (k == 0) ? 8'h01 : 8'($urandom());
            lg = '0;
            lEn = 0;
            lBusy = 0;
            @(negedge clk);
            checkOutput("lsb.ready", lsbReady, 1);
            lsbIn    = lf;
            lsbValid = 1'b1;
            @(posedge clk);
            #1;
            lsbValid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                lg[i] = lsbOut;
                lEn   += int'(lsbOutEn);
                lBusy += int'(lsbBusy);
            end
            checkOutput($sformatf("lsb%0d.seq", k), lg, lf);
            checkOutput($sformatf("lsb%0d.en", k), lEn + lBusy, 16);
            @(negedge clk);
            checkOutput($sformatf("lsb%0d.done", k), {lsbDone, lsbOut, lsbOutEn}, {1'b1, IDLE, 1'b0});
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
